// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top -- small register-programmed ALU.
//
// Three programmable entries (opcode, operand A, operand B) are loaded through
// a simple write port. A hi/lo register pair holds the double-width product of
// the most recent multiply. Everything else is combinational from the stored
// entries, so an operation's result is visible right after the write edge that
// completes it. Multiply is the exception: the product is captured on edges
// where the stored opcode is already MULT.
//
// Ports
//   clk           single clock, all state updates on its rising edge
//   rstN          synchronous reset, active HIGH despite the name; clears all state
//   writeEn       write strobe for the entry file
//   writeAddress  0 = opcode, 1 = operand A, 2 = operand B, 3 = ignored
//   inst          write data
//   result        ALU result
//   error         illegal opcode, divide by zero or rotate amount out of range
//   zero          result == 0 (only when error = 0)
//   carry         ADD carry-out / SUB borrow
//   overflow      ADD/SUB signed overflow, MULT upper half non-zero
// -----------------------------------------------------------------------------
module top #(
  parameter int OPERAND_WIDTH    = 8,
  parameter int INST_ADDR_LENGTH = 2
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        writeEn,
  input  logic [INST_ADDR_LENGTH-1:0] writeAddress,
  input  logic [OPERAND_WIDTH-1:0]    inst,
  output logic [OPERAND_WIDTH-1:0]    result,
  output logic                        error,
  output logic                        zero,
  output logic                        carry,
  output logic                        overflow
);

  localparam int W   = OPERAND_WIDTH;
  localparam int SHW = (W > 1) ? $clog2(W) : 1;

  localparam logic [W-1:0] OP_ADD    = W'(0);
  localparam logic [W-1:0] OP_SUB    = W'(1);
  localparam logic [W-1:0] OP_MULT   = W'(2);
  localparam logic [W-1:0] OP_DIVIDE = W'(3);
  localparam logic [W-1:0] OP_MFHI   = W'(4);
  localparam logic [W-1:0] OP_MFLO   = W'(5);
  localparam logic [W-1:0] OP_AND    = W'(6);
  localparam logic [W-1:0] OP_OR     = W'(7);
  localparam logic [W-1:0] OP_XOR    = W'(8);
  localparam logic [W-1:0] OP_NAND   = W'(9);
  localparam logic [W-1:0] OP_NOR    = W'(10);
  localparam logic [W-1:0] OP_EQUAL  = W'(11);
  localparam logic [W-1:0] OP_GT     = W'(12);
  localparam logic [W-1:0] OP_LT     = W'(13);
  localparam logic [W-1:0] OP_ROTL   = W'(14);
  localparam logic [W-1:0] OP_ROTR   = W'(15);

  // ---------------------------------------------------------------------------
  // State: entry file and hi/lo product registers
  // ---------------------------------------------------------------------------
  logic [W-1:0] opcode_q, opcode_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;

  logic [2*W-1:0] product;

  assign product = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

  always_comb begin
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (writeEn) begin
      if (writeAddress == INST_ADDR_LENGTH'(0)) begin
        opcode_d = inst;
      end else if (writeAddress == INST_ADDR_LENGTH'(1)) begin
        a_d = inst;
      end else if (writeAddress == INST_ADDR_LENGTH'(2)) begin
        b_d = inst;
      end
    end

    // The capture uses the pre-edge opcode and operands, so a write landing on
    // the same edge only affects the next capture.
    if (opcode_q == OP_MULT) begin
      {hi_d, lo_d} = product;
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [SHW-1:0] rot_amt;
  logic [W-1:0]   rotl_w;
  logic [W-1:0]   rotr_w;
  logic           rot_bad;

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  // The extra top bit of the widened subtraction is exactly the borrow (A < B).
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  // Only amounts 0..W-1 are legal; the low bits drive the rotator and the
  // range check flags everything else. A zero amount shifts the wrap-around
  // term by W, which leaves it empty.
  assign rot_amt = b_q[SHW-1:0];
  assign rot_bad = (b_q > W'(W - 1));
  assign rotl_w  = (a_q << rot_amt) | (a_q >> (W - int'(rot_amt)));
  assign rotr_w  = (a_q >> rot_amt) | (a_q << (W - int'(rot_amt)));

  logic [W-1:0] res_raw;
  logic         err_raw;
  logic         cry_raw;
  logic         ovf_raw;

  always_comb begin
    res_raw = '0;
    err_raw = 1'b0;
    cry_raw = 1'b0;
    ovf_raw = 1'b0;

    case (opcode_q)
      OP_ADD: begin
        res_raw = sum_w[W-1:0];
        cry_raw = sum_w[W];
        ovf_raw = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        res_raw = diff_w[W-1:0];
        cry_raw = diff_w[W];
        ovf_raw = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
      end
      OP_MULT: begin
        res_raw = lo_q;
        ovf_raw = (hi_q != '0);
      end
      OP_DIVIDE: begin
        if (b_q == '0) begin
          err_raw = 1'b1;
        end else begin
          res_raw = a_q / b_q;
        end
      end
      OP_MFHI:  res_raw = hi_q;
      OP_MFLO:  res_raw = lo_q;
      OP_AND:   res_raw = a_q & b_q;
      OP_OR:    res_raw = a_q | b_q;
      OP_XOR:   res_raw = a_q ^ b_q;
      OP_NAND:  res_raw = ~(a_q & b_q);
      OP_NOR:   res_raw = ~(a_q | b_q);
      OP_EQUAL: res_raw = W'(a_q == b_q);
      OP_GT:    res_raw = W'(a_q > b_q);
      OP_LT:    res_raw = W'(a_q < b_q);
      OP_ROTL: begin
        if (rot_bad) err_raw = 1'b1;
        else         res_raw = rotl_w;
      end
      OP_ROTR: begin
        if (rot_bad) err_raw = 1'b1;
        else         res_raw = rotr_w;
      end
      default: err_raw = 1'b1;
    endcase
  end

  // Any error forces a clean all-zero result with every other flag low.
  always_comb begin
    result   = '0;
    error    = err_raw;
    zero     = 1'b0;
    carry    = 1'b0;
    overflow = 1'b0;
    if (!err_raw) begin
      result   = res_raw;
      zero     = (res_raw == '0);
      carry    = cry_raw;
      overflow = ovf_raw;
    end
  end

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top -- directed bench for the register-programmed ALU. Each step pushes
// its expected outputs onto a scoreboard queue, drives the writes, then pops
// the entry and compares every output.
// -----------------------------------------------------------------------------
module tb_top;

  logic       clk;
  logic       rstN;
  logic       writeEn;
  logic [1:0] writeAddress;
  logic [7:0] inst;
  logic [7:0] result;
  logic       error;
  logic       zero;
  logic       carry;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       err;
    logic       zro;
    logic       cry;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  top #(
    .OPERAND_WIDTH   (8),
    .INST_ADDR_LENGTH(2)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .writeEn     (writeEn),
    .writeAddress(writeAddress),
    .inst        (inst),
    .result      (result),
    .error       (error),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [7:0] res,
                            input logic err, input logic zro,
                            input logic cry, input logic ovf);
    exp_t e;
    e.tag = tag; e.res = res; e.err = err; e.zro = zro; e.cry = cry; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (result === e.res) else begin
        errors++;
        $error("FAIL %s result observed=%h expected=%h", e.tag, result, e.res);
      end
      checks++;
      assert (error === e.err) else begin
        errors++;
        $error("FAIL %s error observed=%b expected=%b", e.tag, error, e.err);
      end
      checks++;
      assert (zero === e.zro) else begin
        errors++;
        $error("FAIL %s zero observed=%b expected=%b", e.tag, zero, e.zro);
      end
      checks++;
      assert (carry === e.cry) else begin
        errors++;
        $error("FAIL %s carry observed=%b expected=%b", e.tag, carry, e.cry);
      end
      checks++;
      assert (overflow === e.ovf) else begin
        errors++;
        $error("FAIL %s overflow observed=%b expected=%b", e.tag, overflow, e.ovf);
      end
      $display("step %-14s result=%h error=%b zero=%b carry=%b overflow=%b",
               e.tag, result, error, zero, carry, overflow);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    writeEn      = 1'b1;
    writeAddress = addr;
    inst         = data;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
  endtask

  task automatic setup(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    wr(2'd0, op);
    wr(2'd1, a);
    wr(2'd2, b);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rstN = 1'b0;
  endtask

  initial begin
    rstN = 1'b1; writeEn = 1'b0; writeAddress = 2'd0; inst = 8'd0;

    // Reset state: ADD 0+0 in effect
    expect_out("reset", 8'h00, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out();

    // Reset wins over a simultaneous write
    expect_out("rst_over_wr", 8'h00, 0, 1, 0, 0);
    @(negedge clk);
    writeEn = 1'b1; writeAddress = 2'd1; inst = 8'd55;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    check_out();
    @(negedge clk);
    rstN = 1'b0;

    expect_out("add_carry", 8'h2C, 0, 0, 1, 0);
    setup(8'd0, 8'd200, 8'd100);
    check_out();

    expect_out("add_ovf", 8'hC8, 0, 0, 0, 1);
    setup(8'd0, 8'd100, 8'd100);
    check_out();

    expect_out("add_wrap0", 8'h00, 0, 1, 1, 1);
    setup(8'd0, 8'd128, 8'd128);
    check_out();

    expect_out("sub_ovf", 8'h7F, 0, 0, 0, 1);
    setup(8'd1, 8'h80, 8'd1);
    check_out();

    expect_out("sub_borrow", 8'hF6, 0, 0, 1, 0);
    setup(8'd1, 8'd10, 8'd20);
    check_out();

    // MULT: right after writing B, lo still holds 200*20 = 0x0FA0
    expect_out("mult_latency", 8'hA0, 0, 0, 0, 1);
    setup(8'd2, 8'd200, 8'd3);
    check_out();

    expect_out("mult", 8'h58, 0, 0, 0, 1);
    idle_cycle();
    check_out();

    expect_out("mfhi", 8'h02, 0, 0, 0, 0);
    wr(2'd0, 8'd4);
    check_out();

    expect_out("mflo", 8'h58, 0, 0, 0, 0);
    wr(2'd0, 8'd5);
    check_out();

    expect_out("div_by0", 8'h00, 1, 0, 0, 0);
    setup(8'd3, 8'd7, 8'd0);
    check_out();

    expect_out("div", 8'd28, 0, 0, 0, 0);
    setup(8'd3, 8'd200, 8'd7);
    check_out();

    expect_out("rotl1", 8'h03, 0, 0, 0, 0);
    setup(8'd14, 8'h81, 8'd1);
    check_out();

    expect_out("rotr1", 8'hC0, 0, 0, 0, 0);
    setup(8'd15, 8'h81, 8'd1);
    check_out();

    expect_out("rotl7", 8'hC0, 0, 0, 0, 0);
    setup(8'd14, 8'h81, 8'd7);
    check_out();

    expect_out("rotl205", 8'h00, 1, 0, 0, 0);
    setup(8'd14, 8'h81, 8'd205);
    check_out();

    expect_out("rotr8", 8'h00, 1, 0, 0, 0);
    setup(8'd15, 8'h81, 8'd8);
    check_out();

    expect_out("and", 8'h30, 0, 0, 0, 0);
    setup(8'd6, 8'hF0, 8'h3C);
    check_out();
    expect_out("or", 8'hFC, 0, 0, 0, 0);
    wr(2'd0, 8'd7);
    check_out();
    expect_out("xor", 8'hCC, 0, 0, 0, 0);
    wr(2'd0, 8'd8);
    check_out();
    expect_out("nand", 8'hCF, 0, 0, 0, 0);
    wr(2'd0, 8'd9);
    check_out();
    expect_out("nor", 8'h03, 0, 0, 0, 0);
    wr(2'd0, 8'd10);
    check_out();

    expect_out("eq_true", 8'h01, 0, 0, 0, 0);
    setup(8'd11, 8'd5, 8'd5);
    check_out();
    expect_out("gt_equal", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd12);
    check_out();
    expect_out("lt_equal", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd13);
    check_out();
    expect_out("gt_unsigned", 8'h01, 0, 0, 0, 0);
    setup(8'd12, 8'd200, 8'd5);
    check_out();
    expect_out("lt_false", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd13);
    check_out();
    expect_out("eq_false", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd11);
    check_out();

    expect_out("sub_zero", 8'h00, 0, 1, 0, 0);
    setup(8'd1, 8'd9, 8'd9);
    check_out();

    expect_out("op255", 8'h00, 1, 0, 0, 0);
    wr(2'd0, 8'd255);
    check_out();
    expect_out("op16", 8'h00, 1, 0, 0, 0);
    wr(2'd0, 8'd16);
    check_out();

    // Reset in the middle of a multiply sequence discards the product
    setup(8'd2, 8'd15, 8'd17);
    expect_out("mult_reset", 8'h00, 0, 1, 0, 0);
    reset_cycle();
    check_out();
    expect_out("mfhi_reset", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd4);
    check_out();
    expect_out("mflo_reset", 8'h00, 0, 1, 0, 0);
    wr(2'd0, 8'd5);
    check_out();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
